// File: rtl/logic_pkg.sv
// Shared types and helpers for the stream arbiter slice.
// Holds the arbiter state enum and a round-robin index picker.
package logic_pkg;

    // Widest request vector the round-robin helper can scan.
    localparam int RR_MAX = 32;

    typedef enum logic {
        ARBITER_IDLE,
        ARBITER_LOCKED
    } arbiter_state_t;

    // Round-robin pick: the lowest set request strictly above 'last'
    // wins; if none is above it, wrap to the lowest set request.
    // Returns -1 when no request is set.
    function automatic int rr_next(
        input logic [RR_MAX-1:0] req,
        input int                last
    );
        int pick;
        pick = -1;
        for (int i = RR_MAX - 1; i >= 0; i--) begin
            if (req[i]) pick = i;
        end
        for (int i = RR_MAX - 1; i >= 0; i--) begin
            if (req[i] && i > last) pick = i;
        end
        return pick;
    endfunction

endpackage

// File: rtl/logic_axi4_stream_register.sv
// Single-stage AXI4-Stream register slice carrying an opaque payload.
// Ports: aclk/sreset, rx_* upstream handshake, tx_* downstream handshake.
module logic_axi4_stream_register #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             sreset,
    input  logic             rx_tvalid,
    output logic             rx_tready,
    input  logic [WIDTH-1:0] rx_tpayload,
    input  logic             tx_tready,
    output logic             tx_tvalid,
    output logic [WIDTH-1:0] tx_tpayload
);

    // Accept whenever the held beat leaves this cycle or the slot is empty.
    assign rx_tready = tx_tready || !tx_tvalid;

    always_ff @(posedge aclk) begin
        if (sreset) begin
            tx_tvalid   <= 1'b0;
            tx_tpayload <= '0;
        end else if (rx_tready) begin
            tx_tvalid <= rx_tvalid;
            if (rx_tvalid) tx_tpayload <= rx_tpayload;
        end
    end

endmodule

// File: rtl/logic_clock_domain_crossing_arbiter.sv
// Packet-aware round-robin arbiter feeding one CDC channel.
// Ports: aclk/sreset, rx_* per-requester streams, tx_* merged stream + tid.
module logic_clock_domain_crossing_arbiter
    import logic_pkg::*;
#(
    parameter int INPUTS = 2,
    parameter int WIDTH  = 8
) (
    input  logic                        aclk,
    input  logic                        sreset,
    input  logic [INPUTS-1:0]           rx_tvalid,
    input  logic [INPUTS-1:0]           rx_tlast,
    input  logic [INPUTS*WIDTH-1:0]     rx_tdata,
    output logic [INPUTS-1:0]           rx_tready,
    input  logic                        tx_tready,
    output logic                        tx_tvalid,
    output logic                        tx_tlast,
    output logic [$clog2(INPUTS)-1:0]   tx_tid,
    output logic [WIDTH-1:0]            tx_tdata
);

    localparam int ID_WIDTH = $clog2(INPUTS);
    localparam int PW       = ID_WIDTH + 1 + WIDTH;

    if (INPUTS < 2 || INPUTS > RR_MAX) begin : g_drc_inputs
        $error("INPUTS out of range");
    end
    if (WIDTH < 1) begin : g_drc_width
        $error("WIDTH must be >= 1");
    end

    arbiter_state_t      state;
    logic [ID_WIDTH-1:0] last_grant;
    logic [ID_WIDTH-1:0] locked_id;

    logic [RR_MAX-1:0]   req;
    int                  pick;
    logic [INPUTS-1:0]   grant;
    logic [ID_WIDTH-1:0] sel;
    logic                stage_ready;
    logic                xfer;
    logic                sel_last;
    logic [WIDTH-1:0]    sel_data;
    logic [PW-1:0]       stage_out;

    always_comb begin
        req = '0;
        req[INPUTS-1:0] = rx_tvalid;
        pick  = rr_next(req, int'(last_grant));
        grant = '0;
        sel   = locked_id;
        if (state == ARBITER_LOCKED) begin
            grant[locked_id] = 1'b1;
        end else if (pick >= 0) begin
            sel = ID_WIDTH'(pick);
            grant[sel] = 1'b1;
        end
    end

    assign rx_tready = (sreset || !stage_ready) ? '0 : grant;
    assign xfer      = |(rx_tvalid & rx_tready);
    assign sel_data  = rx_tdata[sel*WIDTH +: WIDTH];
    assign sel_last  = rx_tlast[sel];

    always_ff @(posedge aclk) begin
        if (sreset) begin
            state      <= ARBITER_IDLE;
            last_grant <= ID_WIDTH'(INPUTS - 1);
            locked_id  <= '0;
        end else if (xfer) begin
            // In LOCKED, sel is locked_id, so the pointer ends on the owner.
            last_grant <= sel;
            if (state == ARBITER_IDLE) begin
                if (!sel_last) begin
                    state     <= ARBITER_LOCKED;
                    locked_id <= sel;
                end
            end else if (sel_last) begin
                state <= ARBITER_IDLE;
            end
        end
    end

    logic_axi4_stream_register #(
        .WIDTH(PW)
    ) u_out_reg (
        .aclk       (aclk),
        .sreset     (sreset),
        .rx_tvalid  (xfer),
        .rx_tready  (stage_ready),
        .rx_tpayload({sel, sel_last, sel_data}),
        .tx_tready  (tx_tready),
        .tx_tvalid  (tx_tvalid),
        .tx_tpayload(stage_out)
    );

    assign {tx_tid, tx_tlast, tx_tdata} = stage_out;

endmodule
